// File: rtl/tmept_isa_pkg.sv
// Shared ISA definitions for the decode stage: class codes, opcode ranges,
// instruction lengths, field positions and the word-to-fields decoder.
package tmept_isa_pkg;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_JUMP    = 3'd1,
        CLS_LMAR    = 3'd2,
        CLS_IMAR    = 3'd3,
        CLS_CMPBR   = 3'd4,
        CLS_ILLEGAL = 3'd7
    } cls_e;

    // Inclusive upper bound of each opcode class; classes are contiguous from 0x00
    localparam logic [7:0] OP_ALU_MAX   = 8'h25;
    localparam logic [7:0] OP_JUMP_MAX  = 8'h2D;
    localparam logic [7:0] OP_LMAR_MAX  = 8'h31;
    localparam logic [7:0] OP_IMAR_MAX  = 8'h35;
    localparam logic [7:0] OP_CMPBR_MAX = 8'h3F;

    localparam logic [2:0] LEN_ALU     = 3'd3;
    localparam logic [2:0] LEN_JUMP    = 3'd2;
    localparam logic [2:0] LEN_LMAR    = 3'd3;
    localparam logic [2:0] LEN_IMAR    = 3'd2;
    localparam logic [2:0] LEN_CMPBR   = 3'd4;
    localparam logic [2:0] LEN_ILLEGAL = 3'd1;

    localparam int unsigned W0_LSB   = 24;
    localparam int unsigned W1_LSB   = 16;
    localparam int unsigned W2_LSB   = 8;
    localparam int unsigned W3_LSB   = 0;
    localparam int unsigned MODE_LSB = 6;
    localparam int unsigned DST_LSB  = 2;
    localparam int unsigned NIB_HI   = 4;
    localparam int unsigned NIB_LO   = 0;

    typedef struct packed {
        cls_e        cls;
        logic [7:0]  opcode;
        logic [1:0]  mode;
        logic [3:0]  dst;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  jmp;
        logic [15:0] imm16;
        logic [2:0]  len;
    } decoded_t;

    // Fields a class does not use stay zero
    function automatic decoded_t decode_instr(input logic [31:0] w);
        decoded_t   d;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] w2;
        logic [7:0] w3;
        d        = '0;
        w0       = w[W0_LSB +: 8];
        w1       = w[W1_LSB +: 8];
        w2       = w[W2_LSB +: 8];
        w3       = w[W3_LSB +: 8];
        d.opcode = w0;
        if (w0 <= OP_ALU_MAX) begin
            d.cls  = CLS_ALU;
            d.len  = LEN_ALU;
            d.mode = w1[MODE_LSB +: 2];
            d.dst  = w1[DST_LSB +: 4];
            d.src1 = w2[NIB_HI +: 4];
            d.src2 = w2[NIB_LO +: 4];
        end else if (w0 <= OP_JUMP_MAX) begin
            d.cls = CLS_JUMP;
            d.len = LEN_JUMP;
            d.dst = w1[DST_LSB +: 4];
        end else if (w0 <= OP_LMAR_MAX) begin
            d.cls   = CLS_LMAR;
            d.len   = LEN_LMAR;
            d.imm16 = {w1, w2};
        end else if (w0 <= OP_IMAR_MAX) begin
            d.cls = CLS_IMAR;
            d.len = LEN_IMAR;
        end else if (w0 <= OP_CMPBR_MAX) begin
            d.cls  = CLS_CMPBR;
            d.len  = LEN_CMPBR;
            d.src1 = w1[NIB_HI +: 4];
            d.src2 = w1[NIB_LO +: 4];
            d.dst  = w2[NIB_HI +: 4];
            d.jmp  = w3[NIB_HI +: 4];
        end else begin
            d.cls = CLS_ILLEGAL;
            d.len = LEN_ILLEGAL;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode-to-execute bus: raw words in, decoded instruction out.
interface decode_stage_if #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   in_instr;
    logic [AW-1:0] in_pc;
    logic          in_valid;
    logic          flush;
    logic          q_full;
    logic [CW-1:0] q_count;
    logic          overflow;
    logic          d_valid;
    logic          d_ready;
    logic [2:0]    d_class;
    logic [7:0]    d_opcode;
    logic [1:0]    d_mode;
    logic [3:0]    d_dst;
    logic [3:0]    d_src1;
    logic [3:0]    d_src2;
    logic [3:0]    d_jmp;
    logic [15:0]   d_imm16;
    logic [2:0]    d_len;
    logic [AW-1:0] d_pc;

    modport master (
        output in_instr, in_pc, in_valid, flush, d_ready,
        input  q_full, q_count, overflow, d_valid, d_class, d_opcode, d_mode,
               d_dst, d_src1, d_src2, d_jmp, d_imm16, d_len, d_pc
    );

    modport slave (
        input  in_instr, in_pc, in_valid, flush, d_ready,
        output q_full, q_count, overflow, d_valid, d_class, d_opcode, d_mode,
               d_dst, d_src1, d_src2, d_jmp, d_imm16, d_len, d_pc
    );
endinterface

// File: rtl/instr_fifo.sv
// Raw-word FIFO with registered count/full and a synchronous clear for flush.
module instr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = count + CW'(push) - CW'(pop);
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= cnt_nxt;
            full  <= (cnt_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: buffers fetched words, decodes them and holds one registered
// decoded instruction for execute under valid/ready; flush drops everything.
module decode_stage
    import tmept_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 16
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = 32 + AW;

    logic [DW-1:0] head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          load;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          push_ok;
    decoded_t      head_dec;
    decoded_t      in_dec;
    decoded_t      dec_q;
    logic          valid_q;
    logic          ovf_q;
    logic [AW-1:0] pc_q;

    assign head_dec = decode_instr(head[DW-1:AW]);
    assign in_dec   = decode_instr(bus.in_instr);

    // Output slot refills when empty or being consumed; queue head beats bypass
    always_comb begin
        load    = !valid_q || bus.d_ready;
        pop     = !bus.flush && load && !empty;
        bypass  = !bus.flush && load && empty && bus.in_valid;
        push    = !bus.flush && bus.in_valid && !bypass;
        push_ok = push && (!full || pop);
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .push  (push_ok),
        .pop   (pop),
        .wdata ({bus.in_instr, bus.in_pc}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push && !push_ok) ovf_q <= 1'b1;
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (load) begin
                if (!empty) begin
                    valid_q <= 1'b1;
                    dec_q   <= head_dec;
                    pc_q    <= head[AW-1:0];
                end else if (bus.in_valid) begin
                    valid_q <= 1'b1;
                    dec_q   <= in_dec;
                    pc_q    <= bus.in_pc;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.d_valid  = valid_q;
    assign bus.d_class  = dec_q.cls;
    assign bus.d_opcode = dec_q.opcode;
    assign bus.d_mode   = dec_q.mode;
    assign bus.d_dst    = dec_q.dst;
    assign bus.d_src1   = dec_q.src1;
    assign bus.d_src2   = dec_q.src2;
    assign bus.d_jmp    = dec_q.jmp;
    assign bus.d_imm16  = dec_q.imm16;
    assign bus.d_len    = dec_q.len;
    assign bus.d_pc     = pc_q;
    assign bus.q_count  = count;
    assign bus.q_full   = full;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected decodes,
// a negedge monitor pops and compares on every accepted output.
module tb_decode_stage;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    decode_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]    cls;
        logic [7:0]    op;
        logic [1:0]    mode;
        logic [3:0]    dst;
        logic [3:0]    src1;
        logic [3:0]    src2;
        logic [3:0]    jmp;
        logic [15:0]   imm;
        logic [2:0]    len;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int unsigned n_model = 0;   // instructions held: output slot plus queue
    bit          ovf_model = 1'b0;

    // Reference decoder: byte arithmetic on the opcode ranges
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [AW-1:0] pc);
        exp_t        e;
        int unsigned op;
        int unsigned b1;
        int unsigned b2;
        int unsigned b3;
        op = (w >> 24) & 255;
        b1 = (w >> 16) & 255;
        b2 = (w >> 8) & 255;
        b3 = w & 255;
        e  = '{default: 0};
        e.op = 8'(op);
        e.pc = pc;
        if (op < 38) begin
            e.cls = 3'd0; e.len = 3'd3;
            e.mode = 2'(b1 / 64); e.dst = 4'((b1 / 4) % 16);
            e.src1 = 4'(b2 / 16); e.src2 = 4'(b2 % 16);
        end else if (op < 46) begin
            e.cls = 3'd1; e.len = 3'd2; e.dst = 4'((b1 / 4) % 16);
        end else if (op < 50) begin
            e.cls = 3'd2; e.len = 3'd3; e.imm = 16'(b1 * 256 + b2);
        end else if (op < 54) begin
            e.cls = 3'd3; e.len = 3'd2;
        end else if (op < 64) begin
            e.cls = 3'd4; e.len = 3'd4;
            e.src1 = 4'(b1 / 16); e.src2 = 4'(b1 % 16);
            e.dst = 4'(b2 / 16); e.jmp = 4'(b3 / 16);
        end else begin
            e.cls = 3'd7; e.len = 3'd1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Output is accepted at the next edge when valid & ready and no flush
    always @(negedge clk) begin
        if (!rst && bus.d_valid && bus.d_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output actual_opcode=%0h required=none at %0t",
                         bus.d_opcode, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_class",  32'(bus.d_class),  32'(mon_e.cls));
                chk("sb_opcode", 32'(bus.d_opcode), 32'(mon_e.op));
                chk("sb_regs", 32'({bus.d_mode, bus.d_dst, bus.d_src1, bus.d_src2, bus.d_jmp}),
                    32'({mon_e.mode, mon_e.dst, mon_e.src1, mon_e.src2, mon_e.jmp}));
                chk("sb_imm16",  32'(bus.d_imm16),  32'(mon_e.imm));
                chk("sb_len",    32'(bus.d_len),    32'(mon_e.len));
                chk("sb_pc",     32'(bus.d_pc),     32'(mon_e.pc));
            end
        end
    end

    // One cycle: check state after the last edge, drive inputs for the next
    // edge and advance the occupancy model accordingly.
    task automatic cyc(input logic [31:0] w, input logic [AW-1:0] pc,
                       input bit v, input bit fl, input bit rdy);
        int unsigned cons;
        @(posedge clk);
        #2;
        chk("d_valid",  32'(bus.d_valid),  32'(n_model > 0));
        chk("q_count",  32'(bus.q_count),  (n_model > 0) ? 32'(n_model - 1) : 32'd0);
        chk("q_full",   32'(bus.q_full),   32'(n_model == DEPTH + 1));
        chk("overflow", 32'(bus.overflow), 32'(ovf_model));
        bus.in_instr = w;
        bus.in_pc    = pc;
        bus.in_valid = v;
        bus.flush    = fl;
        bus.d_ready  = rdy;
        if (fl) begin
            n_model = 0;
            exp_q.delete();
        end else begin
            cons = (n_model > 0 && rdy) ? 1 : 0;
            if (v) begin
                if (n_model - cons < DEPTH + 1) begin
                    exp_q.push_back(ref_decode(w, pc));
                    n_model++;
                end else begin
                    ovf_model = 1'b1;
                end
            end
            n_model = n_model - cons;
        end
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) cyc(32'h0, '0, 1'b0, 1'b0, rdy);
    endtask

    task automatic random_phase(input int n);
        logic [31:0] w;
        int unsigned op;
        for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 63);
            w  = {8'(op), 24'($urandom)};
            cyc(w, AW'($urandom), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || n_model != 0); i++) idle(1'b1, 1);
        idle(1'b1, 1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_instr = '0;
        bus.in_pc    = '0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.d_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single ALU instruction, one-cycle latency, then empty
        cyc(32'h000C1200, 16'h0003, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1);
        chk("alu_valid", 32'(bus.d_valid), 32'd1);
        chk("alu_fields", 32'({bus.d_class, bus.d_mode, bus.d_dst, bus.d_src1, bus.d_src2}),
            32'({3'd0, 2'd0, 4'd3, 4'd1, 4'd2}));
        chk("alu_len", 32'(bus.d_len), 32'd3);
        chk("alu_pc",  32'(bus.d_pc),  32'h0003);
        idle(1'b1, 1);
        chk("alu_gone", 32'(bus.d_valid), 32'd0);

        // CMPBR, LMAR, JUMP back to back
        cyc(32'h36123040, 16'h0010, 1'b1, 1'b0, 1'b1);
        cyc(32'h2E1A2B00, 16'h0014, 1'b1, 1'b0, 1'b1);
        chk("cmpbr_fields", 32'({bus.d_class, bus.d_src1, bus.d_src2, bus.d_dst, bus.d_jmp}),
            32'({3'd4, 4'd1, 4'd2, 4'd3, 4'd4}));
        chk("cmpbr_len", 32'(bus.d_len), 32'd4);
        cyc(32'h26140000, 16'h0017, 1'b1, 1'b0, 1'b1);
        chk("lmar_imm", 32'({bus.d_class, bus.d_imm16, bus.d_dst}), 32'({3'd2, 16'h1A2B, 4'd0}));
        idle(1'b1, 1);
        chk("jump_dst", 32'({bus.d_class, bus.d_dst, bus.d_len}), 32'({3'd1, 4'd5, 3'd2}));
        idle(1'b1, 3);

        // Back-pressure: one held, two queued, fourth dropped
        cyc(32'h32000000, 16'h0020, 1'b1, 1'b0, 1'b0);
        cyc(32'h27140000, 16'h0022, 1'b1, 1'b0, 1'b0);
        cyc(32'h28180000, 16'h0024, 1'b1, 1'b0, 1'b0);
        cyc(32'h08042300, 16'h0026, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1);
        chk("bp_qcount", 32'(bus.q_count), 32'd2);
        chk("bp_qfull",  32'(bus.q_full),  32'd1);
        chk("bp_ovf",    32'(bus.overflow), 32'd1);
        chk("bp_head",   32'(bus.d_opcode), 32'h32);
        idle(1'b1, 5);

        // Flush with output and queue occupied and a coincident pulse
        cyc(32'h01000000, 16'h0030, 1'b1, 1'b0, 1'b0);
        cyc(32'h02000000, 16'h0031, 1'b1, 1'b0, 1'b0);
        cyc(32'h03000000, 16'h0032, 1'b1, 1'b0, 1'b0);
        cyc(32'h04000000, 16'h0033, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1);
        chk("flush_valid",  32'(bus.d_valid), 32'd0);
        chk("flush_qcount", 32'(bus.q_count), 32'd0);
        idle(1'b1, 4);

        // Illegal opcode: class 7, length 1, fields zero
        cyc(32'h41FFFFFF, 16'h0040, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1);
        chk("illegal_cls", 32'({bus.d_class, bus.d_len}), 32'({3'd7, 3'd1}));
        chk("illegal_fields", 32'({bus.d_mode, bus.d_dst, bus.d_src1, bus.d_src2, bus.d_jmp}), 32'd0);
        chk("illegal_imm", 32'(bus.d_imm16), 32'd0);
        idle(1'b1, 2);

        random_phase(800);
        drain();

        // Asynchronous reset mid-cycle with an instruction held and one queued
        cyc(32'h10000000, 16'h0050, 1'b1, 1'b0, 1'b0);
        cyc(32'h11000000, 16'h0051, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1);
        chk("pre_rst_state", 32'({bus.d_valid, bus.q_count}), 32'({1'b1, 2'd1}));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.d_valid),  32'd0);
        chk("rst_qcount", 32'(bus.q_count), 32'd0);
        chk("rst_ovf",   32'(bus.overflow), 32'd0);
        n_model   = 0;
        ovf_model = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        random_phase(200);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Sits directly downstream of the instruction fetch stage and consumes its `instr`/`instr_valid`/`pc` outputs.
- Buffers fetched words in a small queue, so a one-cycle `instr_valid` pulse is never lost while execute back-pressures.
- Splits each 32-bit word into opcode, class, register and immediate fields.
- Presents one registered decoded instruction to execute under a valid/ready handshake; branch flush discards everything in flight.

Parameters:
- DEPTH, 2, number of raw-instruction queue entries; power of two, at least 2.
- AW, 16, PC width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_instr  in  32  {W0 opcode, W1, W2, W3} from fetch.
- in_pc  in  AW  fetch PC accompanying in_instr (address of next instruction).
- in_valid  in  1  one-cycle pulse from fetch.
- flush  in  1  branch taken (driven with fetch pc_load_en); discards all buffered/held state.
- q_full  out  1  queue full; reserved for future fetch hold.
- q_count  out  $clog2(DEPTH)+1  queue occupancy.
- overflow  out  1  sticky: an in_valid was dropped because the queue was full.
- d_valid  out  1  decoded instruction held.
- d_ready  in  1  execute accepts this cycle.
- d_class  out  3  0=ALU, 1=JUMP, 2=LMAR, 3=IMAR, 4=CMPBR, 7=ILLEGAL.
- d_opcode  out  8  W0.
- d_mode  out  2  ALU W1[7:6]; else 0.
- d_dst  out  4  ALU/JUMP W1[5:2]; CMPBR W2[7:4]; else 0.
- d_src1  out  4  ALU W2[7:4]; CMPBR W1[7:4]; else 0.
- d_src2  out  4  ALU W2[3:0]; CMPBR W1[3:0]; else 0.
- d_jmp  out  4  CMPBR W3[7:4]; else 0.
- d_imm16  out  16  LMAR {W1,W2}; else 0.
- d_len  out  3  instruction byte length: 3, 2, 3, 2, 4; ILLEGAL 1.
- d_pc  out  AW  in_pc captured with the word.

Behaviour:
- Reset: all outputs 0, queue empty, overflow 0. rst acts asynchronously, at any cycle including mid-handshake.
- Opcode classes, from W0:
  - 0x00–0x25: ALU.
  - 0x26–0x2D: JUMP.
  - 0x2E–0x31: LMAR.
  - 0x32–0x35: IMAR.
  - 0x36–0x3F: CMPBR.
  - 0x40–0xFF: ILLEGAL, with d_illegal meaning d_class==7.
- Field selection is combinational on the raw word. Fields not used by the class are forced to 0. Result is registered into the output stage.
- consume = d_valid & d_ready.
- Output register loads when !d_valid or consume:
  - if the queue is non-empty, load the decoded queue head and pop;
  - else if in_valid, load the decoded input directly (bypass, queue untouched);
  - else d_valid←0.
- Input path: an in_valid not taken by bypass is pushed into the queue.
  - Pushing to a full queue is allowed only if a pop occurs the same cycle.
  - Otherwise the word is dropped and overflow←1 (cleared only by rst).
- Latency: in_valid at edge N with empty pipeline gives d_valid=1 after edge N+1. Fields are stable while d_valid & !d_ready.
- Order is strictly FIFO. Queue pointers wrap modulo DEPTH.
- Flush has priority over all else:
  - the queue empties and d_valid←0 on the next edge;
  - an in_valid in the same cycle is discarded;
  - d_ready in the flush cycle has no effect on state;
  - overflow is unaffected.
- q_full = (q_count==DEPTH). Both q_full and q_count are registered.

Decomposition:
- Shared package `tmept_isa_pkg` holds:
  - class codes and opcode range bounds;
  - instruction length constants;
  - field bit positions (W0..W3 slices, mode/dst/src/jmp offsets).
- Natural sub-module: `instr_fifo`, a parameterised DEPTH×(32+AW) synchronous FIFO with count/full/empty and a synchronous clear input for flush.
- Classification/field extraction is a combinational function in the package.

Test Plan:
- Reset, then in_instr=0x000C1200, in_pc=0x0003 pulse, d_ready=1 → next cycle:
  - d_valid=1, class 0, mode 0, dst 3, src1 1, src2 2, len 3, d_pc 0x0003;
  - following cycle d_valid=0.
- Pulses 0x36123040, then 0x2E1A2B00, then 0x26140000 with d_ready=1 → in order:
  - CMPBR: src1 1, src2 2, dst 3, jmp 4, len 4;
  - LMAR: imm16 0x1A2B, dst 0, len 3;
  - JUMP: dst 5, len 2.
- d_ready=0, four pulses (0x32000000, 0x27140000, 0x28180000, 0x08042300) → first held at the output, next two queued (q_full=1, q_count=2), fourth dropped (overflow=1). Then d_ready=1 → IMAR, JMZ dst 5, JMN dst 6 emerge; XOR never appears.
- Queue and output holding two entries, flush=1 with a coincident in_valid → next cycle d_valid=0, q_count=0; the discarded word never emerges.
- Pulse 0x41000000 → d_class=7, d_len=1, all register and immediate fields 0.
- rst asserted mid-cycle with d_valid=1 and q_count=1 → d_valid, q_count and overflow read 0 within the same cycle, before the next clock edge.
